// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the multi-port bridge.
//   BURST_INCR        : burst encoding driven on arburst/awburst
//   RESP_OKAY/SLVERR  : response codes seen on rresp/bresp
//   axi_size_t        : AXI size encoding (bytes = 2**size)
//   w_state_e         : single-beat write sequencer states
package axi_pkg;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [2:0] axi_size_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_RESP
    } w_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[N]     : requests already masked to the grantable set
//   gnt[N]     : one-hot grant (all zero when nothing is requested)
// The search starts at the pointer; the pointer moves to (granted + 1) mod N
// only in cycles that produce a grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            idx;

    // Walk offsets from the farthest to the nearest so the nearest
    // requesting index (relative to the pointer) is the one left standing.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                ptr_d    = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/axi_multi_port_bridge.sv
// Bridges N_PORTS valid/ready request ports onto one AXI3 master.
//   aclk, aresetn            : clock, asynchronous active-low reset
//   req_*                    : per-port request (valid/ready, write, addr, size, len, wdata, wstrb)
//   rsp_valid/data/last/err  : read beats routed by rid (combinational)
//   wr_done                  : one-cycle pulse on the accepted write response of the owner port
//   ar*/r*/aw*/w*/b*         : AXI3 master channels
// Reads are INCR bursts with arid = port index and one outstanding burst per
// port; writes are single-beat, one at a time.  A read hitting the word of the
// write in flight waits until that write's response has been taken.
module axi_multi_port_bridge
    import axi_pkg::*;
#(
    parameter  int N_PORTS = 2,
    parameter  int ID_W    = 4,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int MAX_LEN = 16,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_PORTS-1:0]        req_valid,
    output logic [N_PORTS-1:0]        req_ready,
    input  logic [N_PORTS-1:0]        req_write,
    input  logic [N_PORTS*ADDR_W-1:0] req_addr,
    input  logic [N_PORTS*3-1:0]      req_size,
    input  logic [N_PORTS*8-1:0]      req_len,
    input  logic [N_PORTS*DATA_W-1:0] req_wdata,
    input  logic [N_PORTS*STRB_W-1:0] req_wstrb,
    output logic [N_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_last,
    output logic                      rsp_err,
    output logic [N_PORTS-1:0]        wr_done,
    output logic [ID_W-1:0]           arid,
    output logic [ADDR_W-1:0]         araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_W-1:0]           rid,
    input  logic [DATA_W-1:0]         rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ID_W-1:0]           awid,
    output logic [ADDR_W-1:0]         awaddr,
    output logic [3:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ID_W-1:0]           wid,
    output logic [DATA_W-1:0]         wdata,
    output logic [STRB_W-1:0]         wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [ID_W-1:0]           bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    // Low while in reset and for the first edge after it, so every
    // input-derived output reads 0 until the block is running.
    logic                active;
    logic [N_PORTS-1:0]  rd_out;
    logic [N_PORTS-1:0]  elig;
    logic [N_PORTS-1:0]  gnt;
    logic [PW-1:0]       gidx;
    logic                gnt_rd;
    logic                gnt_wr;
    logic                ar_full;
    logic                ar_free;
    logic                w_busy;
    w_state_e            w_state;
    w_state_e            w_state_nxt;
    logic                aw_done;
    logic                w_done;
    logic [PW-1:0]       w_own;
    logic [ADDR_W-1:0]   sel_addr;
    axi_size_t           sel_size;
    logic [7:0]          sel_len;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;
    logic                unused_b;

    function automatic logic [3:0] clamp_len(input logic [7:0] len);
        if (int'(len) >= MAX_LEN) clamp_len = 4'(MAX_LEN - 1);
        else                      clamp_len = len[3:0];
    endfunction

    // Write responses carry no information the ports need.
    assign unused_b = ^{bid, bresp};

    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = '0;
    assign awlock  = '0;
    assign arcache = '0;
    assign awcache = '0;
    assign arprot  = '0;
    assign awprot  = '0;
    assign awlen   = '0;
    assign wlast   = 1'b1;
    assign rready  = active;
    assign arvalid = ar_full;
    assign awid    = ID_W'(w_own);
    assign wid     = ID_W'(w_own);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) active <= 1'b0;
        else          active <= 1'b1;
    end

    // The AR slot may be reloaded in the cycle it drains.
    assign ar_free = !ar_full || arready;
    assign w_busy  = (w_state != W_IDLE);

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (req_write[i])
                elig[i] = !w_busy;
            else
                elig[i] = ar_free && !rd_out[i] &&
                          !(w_busy && (req_addr[i*ADDR_W+2 +: ADDR_W-2] == awaddr[ADDR_W-1:2]));
        end
        elig = elig & req_valid & {N_PORTS{active}};
    end

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk   (aclk),
        .rst_n (aresetn),
        .req   (elig),
        .gnt   (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (gnt[i]) gidx = PW'(i);
    end

    assign gnt_rd    = (|gnt) && !req_write[gidx];
    assign gnt_wr    = (|gnt) &&  req_write[gidx];
    assign sel_addr  = req_addr [int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_size  = req_size [int'(gidx)*3      +: 3];
    assign sel_len   = req_len  [int'(gidx)*8      +: 8];
    assign sel_wdata = req_wdata[int'(gidx)*DATA_W +: DATA_W];
    assign sel_wstrb = req_wstrb[int'(gidx)*STRB_W +: STRB_W];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_full <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arid    <= '0;
        end else if (gnt_rd) begin
            ar_full <= 1'b1;
            araddr  <= sel_addr;
            arlen   <= clamp_len(sel_len);
            arsize  <= sel_size;
            arid    <= ID_W'(gidx);
        end else if (arvalid && arready) begin
            ar_full <= 1'b0;
        end
    end

    // Beats with an id outside the port range match no port and are dropped.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_PORTS; i++)
            rsp_valid[i] = active && rvalid && (rid == ID_W'(i));
    end

    assign rsp_data = active ? rdata : '0;
    assign rsp_last = active && rlast;
    assign rsp_err  = active && (rresp != RESP_OKAY);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rd_out <= '0;
        else          rd_out <= (rd_out & ~(rsp_valid & {N_PORTS{rlast}})) |
                                (gnt_rd ? gnt : '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_state_nxt;
    end

    // awvalid = !aw_done in W_ADDR, so "aw_done or handshake now" is aw_done | awready.
    always_comb begin
        w_state_nxt = w_state;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        wr_done     = '0;
        case (w_state)
            W_IDLE: if (gnt_wr) w_state_nxt = W_ADDR;
            W_ADDR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_nxt    = W_IDLE;
                    wr_done[w_own] = 1'b1;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            w_own   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (gnt_wr) begin
            awaddr  <= sel_addr;
            awsize  <= sel_size;
            wdata   <= sel_wdata;
            wstrb   <= sel_wstrb;
            w_own   <= gidx;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end
endmodule
